// File: rtl/sccpu_mem_responder.sv
// Memory-side responder for the single-cycle CPU: loadable instruction memory,
// data memory, and LOAD/RUN/HALT sequencing with a saturating run-cycle counter.
module sccpu_mem_responder #(
  parameter int          IMEM_AW   = 5,
  parameter int          DMEM_AW   = 5,
  parameter logic [31:0] HALT_INST = 32'h08000000
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  input  logic [31:0] alu_out,
  input  logic [31:0] data,
  input  logic        wmem,
  output logic [31:0] mem,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        run,
  output logic        halted,
  output logic [31:0] cycle_count
);

  localparam int IW = 1 << IMEM_AW;
  localparam int DW = 1 << DMEM_AW;

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_HALT} state_t;

  state_t               r_state;
  logic [IMEM_AW-1:0]   r_ptr;
  logic [IW-1:0]        r_ivld;
  logic [DW-1:0]        r_dvld;
  logic [31:0]          r_imem [IW];
  logic [31:0]          r_dmem [DW];
  logic                 r_load_ready;
  logic                 r_run;
  logic                 r_halted;
  logic [31:0]          r_cnt;
  logic [31:0]          r_prev_pc;

  logic [IMEM_AW-1:0]   w_iidx;
  logic [DMEM_AW-1:0]   w_didx;
  logic                 w_pc_in;
  logic                 w_d_in;
  logic [31:0]          w_fetch;
  logic                 w_hs;
  logic                 w_load_done;
  logic                 w_store;
  logic                 w_halt;
  logic                 w_unused;

  assign w_iidx  = pc[IMEM_AW+1:2];
  assign w_didx  = alu_out[DMEM_AW+1:2];
  assign w_pc_in = (pc[31:IMEM_AW+2] == '0);
  assign w_d_in  = (alu_out[31:DMEM_AW+2] == '0);
  assign w_unused = ^{pc[1:0], alu_out[1:0]};

  // Reads stay live in HALT so a debugger can still inspect both memories.
  assign w_fetch = (r_state != S_LOAD && w_pc_in && r_ivld[w_iidx]) ? r_imem[w_iidx] : HALT_INST;
  assign inst    = w_fetch;
  assign mem     = (w_d_in && r_dvld[w_didx]) ? r_dmem[w_didx] : '0;

  assign w_hs        = (r_state == S_LOAD) && load_valid && r_load_ready;
  assign w_load_done = w_hs && (load_last || r_ptr == '1);
  assign w_store     = (r_state == S_RUN) && wmem && w_d_in;
  // A jump-to-self on the halt pattern: same pc on two consecutive edges.
  assign w_halt      = (r_state == S_RUN) && (w_fetch == HALT_INST) && (pc == r_prev_pc);

  // Array contents are never reset; the valid bits decide visibility.
  always_ff @(posedge clock) begin
    if (w_hs)    r_imem[r_ptr]  <= load_data;
    if (w_store) r_dmem[w_didx] <= data;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_LOAD;
      r_ptr        <= '0;
      r_ivld       <= '0;
      r_dvld       <= '0;
      r_load_ready <= 1'b0;
      r_run        <= 1'b0;
      r_halted     <= 1'b0;
      r_cnt        <= '0;
      r_prev_pc    <= '0;
    end else begin
      r_prev_pc <= pc;
      case (r_state)
        S_LOAD: begin
          if (w_hs) begin
            r_ivld[r_ptr] <= 1'b1;
            r_ptr         <= r_ptr + IMEM_AW'(1);
          end
          if (w_load_done) begin
            r_state      <= S_RUN;
            r_load_ready <= 1'b0;
            r_run        <= 1'b1;
          end else begin
            r_load_ready <= 1'b1;
          end
        end
        S_RUN: begin
          if (r_cnt != '1) r_cnt <= r_cnt + 32'd1;
          if (w_store) r_dvld[w_didx] <= 1'b1;
          if (w_halt) begin
            r_state  <= S_HALT;
            r_run    <= 1'b0;
            r_halted <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign load_ready  = r_load_ready;
  assign run         = r_run;
  assign halted      = r_halted;
  assign cycle_count = r_cnt;

endmodule

// File: tb/tb_sccpu_mem_responder.sv
// Bench for sccpu_mem_responder: a per-edge behavioural model compared on every
// falling edge, plus directed scenarios with hand-computed literal expectations.
module tb_sccpu_mem_responder;
  localparam logic [31:0] HALT = 32'h08000000;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] pc = '0, alu_out = '0, data = '0, load_data = '0;
  logic        wmem = 1'b0, load_valid = 1'b0, load_last = 1'b0;
  logic [31:0] inst, mem, cycle_count;
  logic        load_ready, run, halted;

  always #5 clock = ~clock;

  sccpu_mem_responder dut (
    .clock(clock), .resetn(resetn), .pc(pc), .inst(inst), .alu_out(alu_out),
    .data(data), .wmem(wmem), .mem(mem), .load_valid(load_valid),
    .load_ready(load_ready), .load_data(load_data), .load_last(load_last),
    .run(run), .halted(halted), .cycle_count(cycle_count)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_imem [32];
  logic [31:0] m_dmem [32];
  bit          m_iv [32];
  bit          m_dv [32];
  int          m_phase;   // 0 loading, 1 running, 2 halted
  int          m_ptr;
  bit          m_rdy;
  logic [31:0] m_cnt, m_prev_pc, m_fi;
  bit          m_done, m_on;

  function automatic logic [31:0] m_inst(input logic [31:0] a);
    if (m_phase == 0 || a >= 32'd128 || !m_iv[int'(a / 4)]) return HALT;
    return m_imem[int'(a / 4)];
  endfunction

  function automatic logic [31:0] m_mem(input logic [31:0] a);
    if (a >= 32'd128 || !m_dv[int'(a / 4)]) return 32'd0;
    return m_dmem[int'(a / 4)];
  endfunction

  task automatic m_reset();
    m_phase = 0; m_ptr = 0; m_rdy = 0; m_cnt = 0; m_prev_pc = 0;
    for (int k = 0; k < 32; k++) begin m_iv[k] = 0; m_dv[k] = 0; end
  endtask

  always @(negedge resetn) m_reset();

  always @(posedge clock) begin
    if (resetn) begin
      m_fi = m_inst(pc);
      case (m_phase)
        0: begin
          m_done = 0;
          if (load_valid && m_rdy) begin
            m_imem[m_ptr] = load_data;
            m_iv[m_ptr]   = 1;
            m_done = load_last || (m_ptr == 31);
            m_ptr++;
          end
          if (m_done) begin m_phase = 1; m_rdy = 0; end
          else m_rdy = 1;
        end
        1: begin
          if (m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 1;
          if (wmem && alu_out < 32'd128) begin
            m_dmem[int'(alu_out / 4)] = data;
            m_dv[int'(alu_out / 4)]   = 1;
          end
          if (m_fi == HALT && pc == m_prev_pc) m_phase = 2;
        end
        default: ;
      endcase
      m_prev_pc = pc;
    end
  end

  always @(negedge clock) begin
    if (m_on) begin
      chk("inst",        inst,        m_inst(pc));
      chk("mem",         mem,         m_mem(alu_out));
      chk("load_ready",  32'(load_ready), 32'(m_rdy));
      chk("run",         32'(run),    32'(m_phase == 1));
      chk("halted",      32'(halted), 32'(m_phase == 2));
      chk("cycle_count", cycle_count, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic do_reset();
    resetn = 1'b0; load_valid = 0; load_last = 0; wmem = 0; pc = 0; alu_out = 0;
    tick(); tick();
    resetn = 1'b1;
  endtask

  logic [31:0] w6 [6] = '{32'h00000827, 32'h0001102a, 32'h00421820,
                          32'h00622020, 32'h00832820, 32'h00a43020};
  logic [31:0] w4 [4] = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};

  initial begin
    int  i, c, rdy_cyc;
    bit  r, v;
    m_reset();
    #1 m_on = 1;

    // S1: reset state, then six words with valid held high
    tick();
    do_reset();
    #1;
    chk("rst_load_ready", 32'(load_ready), 0);
    chk("rst_run",        32'(run), 0);
    chk("rst_halted",     32'(halted), 0);
    chk("rst_cycles",     cycle_count, 0);
    i = 0; rdy_cyc = 0;
    load_valid = 1;
    for (c = 0; c < 40 && i < 6; c++) begin
      load_data = w6[i]; load_last = (i == 5);
      r = load_ready;
      if (r) rdy_cyc++;
      tick();
      if (r) i++;
    end
    load_valid = 0; load_last = 0;
    chk("s1_words",      32'(i), 6);
    chk("s1_edges",      32'(c), 7);
    chk("s1_ready_cyc",  32'(rdy_cyc), 6);
    #1;
    chk("s1_run",        32'(run), 1);
    chk("s1_ready_off",  32'(load_ready), 0);
    pc = 32'h14; #1 chk("s1_pc14", inst, 32'h00a43020);
    pc = 32'h16; #1 chk("s1_pc16", inst, 32'h00a43020);
    pc = 32'h18; #1 chk("s1_pc18", inst, HALT);
    pc = 32'h0;  #1 chk("s1_pc0",  inst, 32'h00000827);

    // S3: store/load ordering and range
    alu_out = 32'h10; data = 32'hDEADBEEF; wmem = 1;
    #1 chk("st_same_cycle", mem, 0);
    tick(); wmem = 0;
    #1 chk("st_next_cycle", mem, 32'hDEADBEEF);
    alu_out = 32'h14; #1 chk("st_unwritten", mem, 0);
    alu_out = 32'h200; data = 32'h12345678; wmem = 1;
    tick(); wmem = 0;
    alu_out = 32'h0;   #1 chk("st_oor_alias", mem, 0);
    alu_out = 32'h200; #1 chk("st_oor_read",  mem, 0);
    alu_out = 32'h10;  #1 chk("st_keep",      mem, 32'hDEADBEEF);

    // S4: hold the halt word for two edges
    pc = 32'h18;
    tick(); #1 chk("h_one_edge", 32'(halted), 0);
    tick(); #1 chk("h_halted", 32'(halted), 1);
    chk("h_run", 32'(run), 0);
    chk("h_cycles", cycle_count, 4);
    alu_out = 32'h14; data = 32'h1; wmem = 1;
    for (int k = 0; k < 10; k++) begin
      tick(); #1 chk("h_frozen", cycle_count, 4);
    end
    wmem = 0;
    #1 chk("h_store_ignored", mem, 0);
    pc = 32'h14; #1 chk("h_debug_read", inst, 32'h00a43020);

    // S2: valid toggled every cycle
    do_reset();
    i = 0; v = 1;
    for (c = 0; c < 40 && i < 4; c++) begin
      load_valid = v; load_data = w4[i]; load_last = (i == 3);
      r = load_ready;
      tick();
      if (r && v) i++;
      v = !v;
    end
    load_valid = 0; load_last = 0;
    chk("tg_words", 32'(i), 4);
    #1 chk("tg_run", 32'(run), 1);
    pc = 32'h8;  #1 chk("tg_pc8",  inst, 32'h33333333);
    pc = 32'h4;  #1 chk("tg_pc4",  inst, 32'h22222222);
    pc = 32'hC;  #1 chk("tg_pcC",  inst, 32'h44444444);
    pc = 32'h10; #1 chk("tg_pc10", inst, HALT);
    pc = 32'h0;

    // S5: fill all 32 words without load_last
    do_reset();
    i = 0; load_valid = 1;
    for (c = 0; c < 80 && i < 32; c++) begin
      load_data = 32'hA0000000 + 32'(i);
      r = load_ready;
      tick();
      if (r) i++;
    end
    chk("full_words", 32'(i), 32);
    load_data = 32'hDEAD0033;
    for (int k = 0; k < 3; k++) begin
      #1 chk("full_no_ready", 32'(load_ready), 0);
      chk("full_run", 32'(run), 1);
      tick();
    end
    load_valid = 0;
    pc = 32'h0;  #1 chk("full_pc0",  inst, 32'hA0000000);
    pc = 32'h7C; #1 chk("full_pc7C", inst, 32'hA000001F);
    pc = 32'h80; #1 chk("full_pc80", inst, HALT);
    pc = 32'h0;

    // S6: async reset mid-RUN after a store
    alu_out = 32'h8; data = 32'hCAFEF00D; wmem = 1;
    tick(); wmem = 0;
    #1 chk("ar_store", mem, 32'hCAFEF00D);
    tick();
    resetn = 0;
    #1;
    chk("ar_run",    32'(run), 0);
    chk("ar_halted", 32'(halted), 0);
    chk("ar_cycles", cycle_count, 0);
    chk("ar_ready",  32'(load_ready), 0);
    pc = 32'h7C; #1 chk("ar_inst", inst, HALT);
    chk("ar_mem", mem, 0);
    pc = 32'h0;
    tick(); resetn = 1;
    tick();
    load_valid = 1; load_last = 1; load_data = 32'h12345678;
    i = 0;
    for (c = 0; c < 10 && i < 1; c++) begin
      r = load_ready;
      tick();
      if (r) i++;
    end
    load_valid = 0; load_last = 0;
    chk("ar_reload", 32'(i), 1);
    #1 chk("ar_rerun", 32'(run), 1);
    pc = 32'h4; #1 chk("ar_old_inst", inst, HALT);
    pc = 32'h0; #1 chk("ar_new_inst", inst, 32'h12345678);
    alu_out = 32'h8; #1 chk("ar_old_data", mem, 0);
    tick(); tick();

    m_on = 0;
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
